// File: rtl/i2c_arb_pkg.sv
// Shared types and helpers for the I2C command arbiter.
// State encoding, command codes and width helper.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [7:0] CMD_I2C_CONFIG = 8'h04;
  localparam logic [7:0] CMD_I2C_WRITE  = 8'h05;
  localparam logic [7:0] CMD_I2C_READ   = 8'h06;

  // Owner index width, never below one bit.
  function automatic int src_w(int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_known_cmd(logic [7:0] t);
    return (t == CMD_I2C_CONFIG) ||
           (t == CMD_I2C_WRITE) ||
           (t == CMD_I2C_READ);
  endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin pick.
// Winner is the first requester after last_i.
module i2c_rr_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int SRC_W   = src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SRC_W-1:0]   last_i,
  output logic               valid_o,
  output logic [SRC_W-1:0]   idx_o
);

  logic [SRC_W-1:0] c;

  // Scan from last_i+1 around the ring, keep the first hit.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    c       = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      c = SRC_W'((int'(last_i) + i) % NUM_SRC);
      if (!valid_o && req_i[c]) begin
        valid_o = 1'b1;
        idx_o   = c;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin owner arbitration for the shared I2C command handler.
// Owner holds the handler from grant until the handler is idle again.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int SRC_W          = src_w(NUM_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      src_req,
  output logic [NUM_SRC-1:0]      src_gnt,
  input  logic [NUM_SRC*8-1:0]    src_cmd_type,
  input  logic [NUM_SRC*16-1:0]   src_cmd_length,
  input  logic [NUM_SRC*8-1:0]    src_cmd_data,
  input  logic [NUM_SRC*16-1:0]   src_cmd_data_index,
  input  logic [NUM_SRC-1:0]      src_cmd_start,
  input  logic [NUM_SRC-1:0]      src_cmd_data_valid,
  input  logic [NUM_SRC-1:0]      src_cmd_done,
  output logic [NUM_SRC-1:0]      src_cmd_ready,
  output logic [NUM_SRC-1:0]      src_upload_req,
  output logic [NUM_SRC-1:0]      src_upload_valid,
  output logic [NUM_SRC-1:0]      src_upload_active,
  output logic [NUM_SRC*8-1:0]    src_upload_data,
  output logic [NUM_SRC*8-1:0]    src_upload_source,
  input  logic [NUM_SRC-1:0]      src_upload_ready,
  output logic [7:0]              hdl_cmd_type,
  output logic [15:0]             hdl_cmd_length,
  output logic [7:0]              hdl_cmd_data,
  output logic [15:0]             hdl_cmd_data_index,
  output logic                    hdl_cmd_start,
  output logic                    hdl_cmd_data_valid,
  output logic                    hdl_cmd_done,
  input  logic                    hdl_cmd_ready,
  input  logic                    hdl_upload_req,
  input  logic                    hdl_upload_valid,
  input  logic                    hdl_upload_active,
  input  logic [7:0]              hdl_upload_data,
  input  logic [7:0]              hdl_upload_source,
  output logic                    hdl_upload_ready,
  input  logic                    hdl_idle,
  output logic [SRC_W-1:0]        owner_id,
  output logic                    busy,
  output logic                    timeout_pulse
);

  localparam int WD_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIM =
    WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e               state_q;
  logic [NUM_SRC-1:0]   gnt_q;
  logic [SRC_W-1:0]     owner_q;
  logic [SRC_W-1:0]     rr_q;
  logic                 start_seen_q;
  logic                 tmo_q;
  logic [WD_W-1:0]      wd_q;

  logic                 pick_vld;
  logic [SRC_W-1:0]     pick_idx;
  logic                 route;
  logic                 own_req;
  logic                 own_start;
  logic                 own_dv;
  logic                 own_done;

  i2c_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr (
    .req_i   (src_req),
    .last_i  (rr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  assign route = (state_q == S_GRANT) ||
                 (state_q == S_DRAIN);

  // Mux owner command onto the handler, route replies back.
  always_comb begin
    hdl_cmd_type       = '0;
    hdl_cmd_length     = '0;
    hdl_cmd_data       = '0;
    hdl_cmd_data_index = '0;
    own_req            = 1'b0;
    own_start          = 1'b0;
    own_dv             = 1'b0;
    own_done           = 1'b0;
    src_cmd_ready      = '0;
    src_upload_req     = '0;
    src_upload_valid   = '0;
    src_upload_active  = '0;
    src_upload_data    = '0;
    src_upload_source  = '0;
    hdl_upload_ready   = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (owner_q == SRC_W'(s)) begin
        hdl_cmd_type       = src_cmd_type[s*8 +: 8];
        hdl_cmd_length     = src_cmd_length[s*16 +: 16];
        hdl_cmd_data       = src_cmd_data[s*8 +: 8];
        hdl_cmd_data_index = src_cmd_data_index[s*16 +: 16];
        own_req            = src_req[s];
        own_start          = src_cmd_start[s];
        own_dv             = src_cmd_data_valid[s];
        own_done           = src_cmd_done[s];
        if (route) begin
          src_cmd_ready[s]            = hdl_cmd_ready;
          src_upload_req[s]           = hdl_upload_req;
          src_upload_valid[s]         = hdl_upload_valid;
          src_upload_active[s]        = hdl_upload_active;
          src_upload_data[s*8 +: 8]   = hdl_upload_data;
          src_upload_source[s*8 +: 8] = hdl_upload_source;
          hdl_upload_ready            = src_upload_ready[s];
        end
      end
    end
  end

  assign hdl_cmd_start      = (state_q == S_GRANT) && own_start;
  assign hdl_cmd_data_valid = (state_q == S_GRANT) && own_dv;
  assign hdl_cmd_done       = (state_q == S_GRANT) && own_done;

  // Ownership FSM with drain watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      rr_q         <= '0;
      start_seen_q <= 1'b0;
      tmo_q        <= 1'b0;
      wd_q         <= '0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (hdl_idle && pick_vld) begin
            state_q      <= S_GRANT;
            gnt_q        <= NUM_SRC'(1) << pick_idx;
            owner_q      <= pick_idx;
            start_seen_q <= 1'b0;
          end
        end
        S_GRANT: begin
          if (own_done) begin
            state_q <= S_DRAIN;
            wd_q    <= '0;
          end else if (!own_req && !start_seen_q &&
                       !own_start) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            rr_q    <= owner_q;
          end else if (own_start) begin
            start_seen_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (hdl_idle && !hdl_upload_req) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            rr_q         <= owner_q;
            start_seen_q <= 1'b0;
          end else if (TIMEOUT_CYCLES != 0 &&
                       wd_q == WD_LIM) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            rr_q         <= owner_q;
            start_seen_q <= 1'b0;
            tmo_q        <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign src_gnt       = gnt_q;
  assign owner_id      = owner_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_pulse = tmo_q;

  a_cmd_known: assert property (
    @(posedge clk) disable iff (!rst_n)
    hdl_cmd_start |-> is_known_cmd(hdl_cmd_type));

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter.
// The bench plays both command sources and the handler.
module tb_i2c_cmd_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  src_req;
  logic [1:0]  src_gnt;
  logic [15:0] src_cmd_type;
  logic [31:0] src_cmd_length;
  logic [15:0] src_cmd_data;
  logic [31:0] src_cmd_data_index;
  logic [1:0]  src_cmd_start;
  logic [1:0]  src_cmd_data_valid;
  logic [1:0]  src_cmd_done;
  logic [1:0]  src_cmd_ready;
  logic [1:0]  src_upload_req;
  logic [1:0]  src_upload_valid;
  logic [1:0]  src_upload_active;
  logic [15:0] src_upload_data;
  logic [15:0] src_upload_source;
  logic [1:0]  src_upload_ready;
  logic [7:0]  hdl_cmd_type;
  logic [15:0] hdl_cmd_length;
  logic [7:0]  hdl_cmd_data;
  logic [15:0] hdl_cmd_data_index;
  logic        hdl_cmd_start;
  logic        hdl_cmd_data_valid;
  logic        hdl_cmd_done;
  logic        hdl_cmd_ready;
  logic        hdl_upload_req;
  logic        hdl_upload_valid;
  logic        hdl_upload_active;
  logic [7:0]  hdl_upload_data;
  logic [7:0]  hdl_upload_source;
  logic        hdl_upload_ready;
  logic        hdl_idle;
  logic [0:0]  owner_id;
  logic        busy;
  logic        timeout_pulse;

  int chk;
  int err;

  i2c_cmd_arbiter #(
    .NUM_SRC        (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .src_req            (src_req),
    .src_gnt            (src_gnt),
    .src_cmd_type       (src_cmd_type),
    .src_cmd_length     (src_cmd_length),
    .src_cmd_data       (src_cmd_data),
    .src_cmd_data_index (src_cmd_data_index),
    .src_cmd_start      (src_cmd_start),
    .src_cmd_data_valid (src_cmd_data_valid),
    .src_cmd_done       (src_cmd_done),
    .src_cmd_ready      (src_cmd_ready),
    .src_upload_req     (src_upload_req),
    .src_upload_valid   (src_upload_valid),
    .src_upload_active  (src_upload_active),
    .src_upload_data    (src_upload_data),
    .src_upload_source  (src_upload_source),
    .src_upload_ready   (src_upload_ready),
    .hdl_cmd_type       (hdl_cmd_type),
    .hdl_cmd_length     (hdl_cmd_length),
    .hdl_cmd_data       (hdl_cmd_data),
    .hdl_cmd_data_index (hdl_cmd_data_index),
    .hdl_cmd_start      (hdl_cmd_start),
    .hdl_cmd_data_valid (hdl_cmd_data_valid),
    .hdl_cmd_done       (hdl_cmd_done),
    .hdl_cmd_ready      (hdl_cmd_ready),
    .hdl_upload_req     (hdl_upload_req),
    .hdl_upload_valid   (hdl_upload_valid),
    .hdl_upload_active  (hdl_upload_active),
    .hdl_upload_data    (hdl_upload_data),
    .hdl_upload_source  (hdl_upload_source),
    .hdl_upload_ready   (hdl_upload_ready),
    .hdl_idle           (hdl_idle),
    .owner_id           (owner_id),
    .busy               (busy),
    .timeout_pulse      (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    src_req = '0;
    src_cmd_type = '0;
    src_cmd_length = '0;
    src_cmd_data = '0;
    src_cmd_data_index = '0;
    src_cmd_start = '0;
    src_cmd_data_valid = '0;
    src_cmd_done = '0;
    src_upload_ready = '0;
    hdl_cmd_ready = 1'b1;
    hdl_upload_req = 1'b0;
    hdl_upload_valid = 1'b0;
    hdl_upload_active = 1'b0;
    hdl_upload_data = '0;
    hdl_upload_source = '0;
    hdl_idle = 1'b1;
    repeat (3) @(negedge clk);
    chk++;
    if (src_gnt !== 2'b00) begin
      err++;
      $display("FAIL rst_gnt: got %b exp 00", src_gnt);
    end
    chk++;
    if (busy !== 1'b0 || timeout_pulse !== 1'b0) begin
      err++;
      $display("FAIL rst_busy: got busy=%b tmo=%b exp 0 0",
               busy, timeout_pulse);
    end
    chk++;
    if (owner_id !== 1'b0) begin
      err++;
      $display("FAIL rst_owner: got %b exp 0", owner_id);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_config();
    @(negedge clk);
    src_req = 2'b01;
    src_cmd_type[7:0] = 8'h04;
    src_cmd_length[15:0] = 16'd1;
    src_cmd_data[7:0] = 8'h68;
    #1;
    chk++;
    if (src_gnt !== 2'b00) begin
      err++;
      $display("FAIL cfg_gnt_early: got %b exp 00", src_gnt);
    end
    @(negedge clk);
    chk++;
    if (src_gnt !== 2'b01 || owner_id !== 1'b0) begin
      err++;
      $display("FAIL cfg_gnt: got %b/%b exp 01/0",
               src_gnt, owner_id);
    end
    chk++;
    if (src_cmd_ready !== 2'b01) begin
      err++;
      $display("FAIL cfg_ready: got %b exp 01", src_cmd_ready);
    end
    src_cmd_start = 2'b01;
    src_cmd_done = 2'b10;
    #1;
    chk++;
    if (hdl_cmd_start !== 1'b1 || hdl_cmd_type !== 8'h04 ||
        hdl_cmd_length !== 16'd1 || hdl_cmd_done !== 1'b0) begin
      err++;
      $display("FAIL cfg_start: got st=%b ty=%h len=%h dn=%b exp 1 04 0001 0",
               hdl_cmd_start, hdl_cmd_type, hdl_cmd_length,
               hdl_cmd_done);
    end
    @(negedge clk);
    src_cmd_start = 2'b00;
    src_cmd_done = 2'b00;
    src_cmd_data_valid = 2'b01;
    #1;
    chk++;
    if (hdl_cmd_data_valid !== 1'b1 || hdl_cmd_data !== 8'h68 ||
        src_gnt !== 2'b01) begin
      err++;
      $display("FAIL cfg_data: got dv=%b d=%h g=%b exp 1 68 01",
               hdl_cmd_data_valid, hdl_cmd_data, src_gnt);
    end
    @(negedge clk);
    src_cmd_data_valid = 2'b00;
    src_cmd_done = 2'b01;
    #1;
    chk++;
    if (hdl_cmd_done !== 1'b1) begin
      err++;
      $display("FAIL cfg_done: got %b exp 1", hdl_cmd_done);
    end
    @(negedge clk);
    src_cmd_done = 2'b00;
    src_req = 2'b00;
    src_cmd_start = 2'b01;
    #1;
    chk++;
    if (busy !== 1'b1 || src_gnt !== 2'b01 ||
        hdl_cmd_start !== 1'b0) begin
      err++;
      $display("FAIL cfg_drain: got b=%b g=%b st=%b exp 1 01 0",
               busy, src_gnt, hdl_cmd_start);
    end
    src_cmd_start = 2'b00;
    @(negedge clk);
    chk++;
    if (src_gnt !== 2'b00 || busy !== 1'b0) begin
      err++;
      $display("FAIL cfg_release: got g=%b b=%b exp 00 0",
               src_gnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    src_req = 2'b11;
    src_cmd_type = 16'h0505;
    src_cmd_length = {16'd4, 16'd4};
    src_cmd_data = 16'h2211;
    @(negedge clk);
    chk++;
    if (src_gnt !== 2'b10 || owner_id !== 1'b1) begin
      err++;
      $display("FAIL b2b_gnt1: got %b/%b exp 10/1",
               src_gnt, owner_id);
    end
    src_cmd_start = 2'b11;
    #1;
    chk++;
    if (hdl_cmd_start !== 1'b1 || hdl_cmd_data !== 8'h22 ||
        src_cmd_ready !== 2'b10) begin
      err++;
      $display("FAIL b2b_mux1: got st=%b d=%h rdy=%b exp 1 22 10",
               hdl_cmd_start, hdl_cmd_data, src_cmd_ready);
    end
    @(negedge clk);
    src_cmd_start = 2'b00;
    src_cmd_done = 2'b10;
    hdl_idle = 1'b0;
    @(negedge clk);
    src_cmd_done = 2'b00;
    src_cmd_start = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk++;
      if (src_gnt !== 2'b10 || hdl_cmd_start !== 1'b0) begin
        err++;
        $display("FAIL b2b_hold%0d: got g=%b st=%b exp 10 0",
                 i, src_gnt, hdl_cmd_start);
      end
    end
    src_cmd_start = 2'b00;
    hdl_idle = 1'b1;
    src_req = 2'b01;
    @(negedge clk);
    chk++;
    if (src_gnt !== 2'b00 || busy !== 1'b0) begin
      err++;
      $display("FAIL b2b_gap: got g=%b b=%b exp 00 0",
               src_gnt, busy);
    end
    @(negedge clk);
    chk++;
    if (src_gnt !== 2'b01) begin
      err++;
      $display("FAIL b2b_gnt0: got %b exp 01", src_gnt);
    end
    src_cmd_start = 2'b01;
    #1;
    chk++;
    if (hdl_cmd_start !== 1'b1 || hdl_cmd_data !== 8'h11) begin
      err++;
      $display("FAIL b2b_mux0: got st=%b d=%h exp 1 11",
               hdl_cmd_start, hdl_cmd_data);
    end
    @(negedge clk);
    src_cmd_start = 2'b00;
    src_cmd_done = 2'b01;
    @(negedge clk);
    src_cmd_done = 2'b00;
    src_req = 2'b00;
    @(negedge clk);
    chk++;
    if (src_gnt !== 2'b00) begin
      err++;
      $display("FAIL b2b_end: got %b exp 00", src_gnt);
    end
  endtask

  task automatic test_read_upload();
    logic [7:0] ub [3];
    ub[0] = 8'hA1;
    ub[1] = 8'hA2;
    ub[2] = 8'hA3;
    @(negedge clk);
    src_req = 2'b10;
    src_cmd_type[15:8] = 8'h06;
    src_cmd_length[31:16] = 16'h0003;
    src_cmd_data[15:8] = 8'h10;
    @(negedge clk);
    chk++;
    if (src_gnt !== 2'b10) begin
      err++;
      $display("FAIL rd_gnt: got %b exp 10", src_gnt);
    end
    src_cmd_start = 2'b10;
    #1;
    chk++;
    if (hdl_cmd_type !== 8'h06 || hdl_cmd_length !== 16'h0003) begin
      err++;
      $display("FAIL rd_cmd: got ty=%h len=%h exp 06 0003",
               hdl_cmd_type, hdl_cmd_length);
    end
    @(negedge clk);
    src_cmd_start = 2'b00;
    src_cmd_done = 2'b10;
    hdl_idle = 1'b0;
    @(negedge clk);
    src_cmd_done = 2'b00;
    hdl_upload_req = 1'b1;
    hdl_upload_active = 1'b1;
    src_upload_ready = 2'b10;
    #1;
    chk++;
    if (src_upload_req !== 2'b10 || src_upload_active !== 2'b10 ||
        hdl_upload_ready !== 1'b1) begin
      err++;
      $display("FAIL rd_upreq: got rq=%b ac=%b hr=%b exp 10 10 1",
               src_upload_req, src_upload_active, hdl_upload_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      hdl_upload_valid = 1'b1;
      hdl_upload_data = ub[k];
      hdl_upload_source = 8'h06;
      src_upload_ready = (k == 1) ? 2'b01 : 2'b10;
      #1;
      chk++;
      if (src_upload_valid !== 2'b10 ||
          src_upload_data !== {ub[k], 8'h00} ||
          src_upload_source !== 16'h0600 ||
          hdl_upload_ready !== (k != 1)) begin
        err++;
        $display("FAIL rd_byte%0d: got v=%b d=%h s=%h hr=%b exp 10 %h00 0600 %b",
                 k, src_upload_valid, src_upload_data,
                 src_upload_source, hdl_upload_ready, ub[k],
                 (k != 1));
      end
    end
    @(negedge clk);
    hdl_upload_valid = 1'b0;
    hdl_upload_req = 1'b0;
    hdl_upload_active = 1'b0;
    hdl_idle = 1'b1;
    src_req = 2'b00;
    src_upload_ready = 2'b00;
    #1;
    chk++;
    if (src_gnt !== 2'b10) begin
      err++;
      $display("FAIL rd_hold: got %b exp 10", src_gnt);
    end
    @(negedge clk);
    chk++;
    if (src_gnt !== 2'b00 || src_upload_req !== 2'b00) begin
      err++;
      $display("FAIL rd_release: got g=%b rq=%b exp 00 00",
               src_gnt, src_upload_req);
    end
  endtask

  task automatic test_abandon();
    int starts;
    starts = 0;
    @(negedge clk);
    src_req = 2'b11;
    src_cmd_type[7:0] = 8'h05;
    @(negedge clk);
    chk++;
    if (src_gnt !== 2'b01) begin
      err++;
      $display("FAIL ab_gnt0: got %b exp 01", src_gnt);
    end
    src_req = 2'b10;
    #1;
    if (hdl_cmd_start === 1'b1) starts++;
    @(negedge clk);
    if (hdl_cmd_start === 1'b1) starts++;
    chk++;
    if (src_gnt !== 2'b00 || busy !== 1'b0) begin
      err++;
      $display("FAIL ab_drop: got g=%b b=%b exp 00 0",
               src_gnt, busy);
    end
    chk++;
    if (starts != 0) begin
      err++;
      $display("FAIL ab_nostart: got %0d starts exp 0", starts);
    end
    @(negedge clk);
    chk++;
    if (src_gnt !== 2'b10) begin
      err++;
      $display("FAIL ab_gnt1: got %b exp 10", src_gnt);
    end
    src_cmd_start = 2'b10;
    @(negedge clk);
    src_cmd_start = 2'b00;
    src_cmd_done = 2'b10;
    @(negedge clk);
    src_cmd_done = 2'b00;
    src_req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int hit;
    hit = 0;
    @(negedge clk);
    src_req = 2'b01;
    @(negedge clk);
    chk++;
    if (src_gnt !== 2'b01) begin
      err++;
      $display("FAIL to_gnt: got %b exp 01", src_gnt);
    end
    src_cmd_start = 2'b01;
    @(negedge clk);
    src_cmd_start = 2'b00;
    src_cmd_done = 2'b01;
    hdl_idle = 1'b0;
    @(negedge clk);
    src_cmd_done = 2'b00;
    src_req = 2'b11;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (timeout_pulse === 1'b1) begin
        hit = n;
        break;
      end
    end
    chk++;
    if (hit != 100) begin
      err++;
      $display("FAIL to_cycle: got %0d exp 100", hit);
    end
    chk++;
    if (busy !== 1'b0 || src_gnt !== 2'b00) begin
      err++;
      $display("FAIL to_idle: got b=%b g=%b exp 0 00",
               busy, src_gnt);
    end
    hdl_idle = 1'b1;
    src_req = 2'b10;
    @(negedge clk);
    chk++;
    if (timeout_pulse !== 1'b0 || src_gnt !== 2'b10) begin
      err++;
      $display("FAIL to_regrant: got p=%b g=%b exp 0 10",
               timeout_pulse, src_gnt);
    end
  endtask

  task automatic test_reset_mid();
    src_cmd_start = 2'b10;
    @(negedge clk);
    src_cmd_start = 2'b00;
    src_cmd_done = 2'b10;
    hdl_idle = 1'b0;
    @(negedge clk);
    src_cmd_done = 2'b00;
    hdl_upload_req = 1'b1;
    hdl_upload_valid = 1'b1;
    hdl_upload_active = 1'b1;
    hdl_upload_data = 8'h5A;
    src_upload_ready = 2'b11;
    #1;
    chk++;
    if (src_upload_valid !== 2'b10 || busy !== 1'b1) begin
      err++;
      $display("FAIL rm_pre: got v=%b b=%b exp 10 1",
               src_upload_valid, busy);
    end
    #1;
    rst_n = 1'b0;
    src_cmd_start = 2'b10;
    #1;
    chk++;
    if (src_gnt !== 2'b00 || src_upload_valid !== 2'b00 ||
        src_upload_data !== 16'h0000 ||
        hdl_upload_ready !== 1'b0 || hdl_cmd_start !== 1'b0) begin
      err++;
      $display("FAIL rm_async: got g=%b v=%b d=%h hr=%b st=%b exp 00 00 0000 0 0",
               src_gnt, src_upload_valid, src_upload_data,
               hdl_upload_ready, hdl_cmd_start);
    end
    src_cmd_start = 2'b00;
    hdl_upload_req = 1'b0;
    hdl_upload_valid = 1'b0;
    hdl_upload_active = 1'b0;
    hdl_idle = 1'b1;
    src_req = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk++;
    if (src_gnt !== 2'b01 || owner_id !== 1'b0) begin
      err++;
      $display("FAIL rm_regrant: got %b/%b exp 01/0",
               src_gnt, owner_id);
    end
  endtask

  initial begin
    chk = 0;
    err = 0;
    test_reset();
    test_config();
    test_back_to_back();
    test_read_upload();
    test_abandon();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             chk, err);
    $finish;
  end

endmodule
